// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the multiply/divide sequencer: operation encodings,
// the sequencer state enum, the divider iteration count and a small
// two's-complement magnitude helper used for sign handling.
// -----------------------------------------------------------------------------
package mdu_pkg;

    localparam int XLEN      = 32;
    localparam int DIV_ITERS = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } mdu_state_e;

    // Conditional two's-complement negation. Used both to take |x| at launch
    // and to restore signs after division. -0x80000000 is 0x80000000, which is
    // exactly the unsigned magnitude the divider expects.
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v,
                                                 input logic            neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// -----------------------------------------------------------------------------
// mdu_ctrl_if
// Pipeline <-> multiply/divide unit bundle.
//   start/op/src_a/src_b : launch request, sampled only while busy is low
//   flush                : cancel whatever is in flight
//   hi_we/lo_we/wdata    : MTHI/MTLO writes, honoured only while busy is low
//   busy/done/hi/lo      : status and architectural HI/LO
// Handshake: the pipeline may present start at any time; the unit accepts it
// on a rising edge where busy is low and flush is low. busy stays high from the
// accepting edge until the cycle after the one-cycle done pulse, so the
// pipeline holds the instruction (and any HI/LO consumer) while busy is high.
// -----------------------------------------------------------------------------
interface mdu_ctrl_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, src_a, src_b, flush, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, flush, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_div_step.sv
// -----------------------------------------------------------------------------
// mdu_div_step
// One combinational restoring-division step.
//   rq_i      : {rem, quo} before the step
//   divisor_i : unsigned divisor magnitude
//   rq_o      : {rem, quo} after shifting left and conditionally subtracting
// The shifted remainder needs 33 bits: a remainder just below a divisor near
// 2^32 doubles past 32 bits before the subtract brings it back.
// -----------------------------------------------------------------------------
module mdu_div_step
    import mdu_pkg::*;
(
    input  logic [2*XLEN-1:0] rq_i,
    input  logic [XLEN-1:0]   divisor_i,
    output logic [2*XLEN-1:0] rq_o
);

    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] sub;
    logic            fits;

    always_comb begin
        rem_sh = rq_i[2*XLEN-1:XLEN-1];
        fits   = (rem_sh >= {1'b0, divisor_i});
        // When fits is set the true difference is below the divisor, so the
        // low 32 bits of the wrap-around subtract are exact.
        sub    = rem_sh[XLEN-1:0] - divisor_i;
        if (fits) begin
            rq_o = {sub, rq_i[XLEN-2:0], 1'b1};
        end else begin
            rq_o = {rem_sh[XLEN-1:0], rq_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl
// Multi-cycle multiply/divide sequencer owning the architectural HI/LO pair.
//   clk, rst     : clock and synchronous active-high reset
//   bus (slave)  : launch, flush, MTHI/MTLO and HI/LO/busy/done status
//   dbg_state_o  : current sequencer state, for observation only
// MULT/MULTU form the 64-bit product at the launch edge and carry it through a
// MUL_CYCLES-deep register chain. DIV/DIVU run 32 restoring steps on operand
// magnitudes, then a FIX cycle restores signs. Both commit HI/LO on the edge
// that enters DONE, and done is high for exactly that DONE cycle.
// -----------------------------------------------------------------------------
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = 2,
    parameter int WIDTH      = 32
) (
    input  logic       clk,
    input  logic       rst,
    mdu_ctrl_if.slave  bus,
    output mdu_state_e dbg_state_o
);

    localparam logic [4:0] MUL_LAST = 5'(MUL_CYCLES - 1);
    localparam logic [4:0] DIV_LAST = 5'(DIV_ITERS - 1);

    mdu_state_e         state_q;
    logic [4:0]         cnt_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               busy_q, done_q;
    logic               qneg_q, rneg_q, bzero_q;
    logic [WIDTH-1:0]   divisor_q;
    logic [2*WIDTH-1:0] rq_q;
    logic [2*WIDTH-1:0] rq_d;
    logic [2*WIDTH-1:0] prod_q [MUL_CYCLES];

    // Launch-side decode of the live operands.
    logic               is_signed;
    logic               a_neg, b_neg;
    logic [2*WIDTH-1:0] ext_a, ext_b, product;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic               launch;

    always_comb begin
        is_signed = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);
        a_neg     = is_signed & bus.src_a[WIDTH-1];
        b_neg     = is_signed & bus.src_b[WIDTH-1];
        // Sign- or zero-extend to 64 bits; the low 64 bits of the extended
        // product are the correct signed or unsigned result.
        ext_a     = {{WIDTH{a_neg}}, bus.src_a};
        ext_b     = {{WIDTH{b_neg}}, bus.src_b};
        product   = ext_a * ext_b;
        launch    = (state_q == IDLE) && bus.start && !bus.flush;
        // Divide by zero keeps the all-ones quotient unsigned; the remainder
        // fix still runs, which turns |A| back into A.
        quo_fix   = cond_neg(rq_q[WIDTH-1:0], qneg_q & ~bzero_q);
        rem_fix   = cond_neg(rq_q[2*WIDTH-1:WIDTH], rneg_q);
    end

    mdu_div_step u_div_step (
        .rq_i      (rq_q),
        .divisor_i (divisor_q),
        .rq_o      (rq_d)
    );

    // Product chain: stage 0 loads at launch, later stages follow one per
    // cycle, so stage MUL_CYCLES-1 is valid on the edge that leaves MUL.
    always_ff @(posedge clk) begin
        if (launch && !bus.op[1]) begin
            prod_q[0] <= product;
        end
        for (int i = 1; i < MUL_CYCLES; i++) begin
            prod_q[i] <= prod_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            bzero_q   <= 1'b0;
            divisor_q <= '0;
            rq_q      <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.flush) begin
                // Cancel without touching HI/LO; also blocks a same-cycle launch.
                state_q <= IDLE;
                cnt_q   <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.hi_we) hi_q <= bus.wdata;
                        if (bus.lo_we) lo_q <= bus.wdata;
                        if (bus.start) begin
                            busy_q    <= 1'b1;
                            cnt_q     <= '0;
                            qneg_q    <= a_neg ^ b_neg;
                            rneg_q    <= a_neg;
                            bzero_q   <= (bus.src_b == '0);
                            divisor_q <= cond_neg(bus.src_b, b_neg);
                            rq_q      <= {{WIDTH{1'b0}}, cond_neg(bus.src_a, a_neg)};
                            state_q   <= bus.op[1] ? DIV : MUL;
                        end
                    end
                    MUL: begin
                        if (cnt_q == MUL_LAST) begin
                            hi_q    <= prod_q[MUL_CYCLES-1][2*WIDTH-1:WIDTH];
                            lo_q    <= prod_q[MUL_CYCLES-1][WIDTH-1:0];
                            done_q  <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= DONE;
                        end else begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                    DIV: begin
                        rq_q <= rq_d;
                        if (cnt_q == DIV_LAST) begin
                            cnt_q   <= '0;
                            state_q <= FIX;
                        end else begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                    FIX: begin
                        hi_q    <= rem_fix;
                        lo_q    <= quo_fix;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                    DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign dbg_state_o = state_q;

endmodule
